kgp_dmem_responder: RTL and testbench
=====================================

KGP_DMEM_RESPONDER -- requirements
Module: kgp_dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, word-address width (memory depth 2^ADDR_BITS 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, number of wait states per access, legal range 0..15.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port dmem_enable  input  1  request valid from the core.
REQ-006 SHALL have port dmem_write_enable  input  1  1 = store, 0 = load; sampled only with dmem_enable.
REQ-007 SHALL have port addr  input  32  byte address.
REQ-008 SHALL have port wdata  input  32  store data.
REQ-009 SHALL have port rdata  output  32  load data.
REQ-010 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port busy  output  1  request accepted and not yet completed.
REQ-012 SHALL have port err  output  1  access fault, valid with ready.

Function
REQ-013 SHALL implement a state machine with states IDLE, WAIT and DONE.
REQ-014 SHALL, in IDLE with dmem_enable=1, latch addr, wdata and dmem_write_enable and load the wait counter with WAIT_CYCLES.
REQ-015 SHALL move IDLE->DONE after the accept edge when WAIT_CYCLES=0, and IDLE->WAIT otherwise.
REQ-016 SHALL, in WAIT, decrement the counter each cycle and move to DONE on the edge where the counter equals 1.
REQ-017 SHALL assert ready=1 for exactly the one DONE cycle, then return to IDLE.
REQ-018 SHALL assert ready exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-019 SHALL hold busy=1 in WAIT and DONE and busy=0 in IDLE.
REQ-020 SHALL ignore dmem_enable while busy=1; a request seen in the DONE cycle is not accepted, and the earliest next accept is the following IDLE cycle.
REQ-021 SHALL compute the word index as latched addr[ADDR_BITS+1:2]; addr[1:0] selects no bytes.
REQ-022 SHALL, for a store, write the latched wdata on the DONE edge and leave rdata unchanged.
REQ-023 SHALL, for a load, drive the memory word on rdata during the ready cycle and hold it until the next load completes.
REQ-024 SHALL treat an accepted request as final: later input changes do not affect the request in flight.

Reset
REQ-025 SHALL, with rst=1 at a rising edge, force state IDLE, ready=0, busy=0, err=0, rdata=0 and counter=0.
REQ-026 SHALL, on reset mid-operation, abort the access with no memory write; ready stays 0.
REQ-027 SHALL leave memory contents unaffected by reset.
REQ-028 SHALL give rst priority over dmem_enable on the same edge.

Configuration
REQ-029 SHALL, with DMEM_BOUNDS_CHECK_EN defined, flag as faulting any request whose addr[31:ADDR_BITS+2] is nonzero or whose addr[1:0] is nonzero.
REQ-030 SHALL complete a faulting request with normal ready timing, err=1 during ready, no write, and rdata=0.
REQ-031 SHALL, without DMEM_BOUNDS_CHECK_EN, tie err to 0 and ignore the upper address bits, so addresses alias modulo the memory size.

Verification
REQ-032 SHALL be verified by: reset, then store 0xDEADBEEF to addr 0x10 with WAIT_CYCLES=2 -> ready high 3 cycles after accept, busy high for those 3 cycles.
REQ-033 SHALL be verified by: load from addr 0x10 after REQ-032 -> rdata=0xDEADBEEF during ready, held through 5 idle cycles.
REQ-034 SHALL be verified by: dmem_enable held high continuously with WAIT_CYCLES=0 -> accepts every second cycle, ready pulses every second cycle.
REQ-035 SHALL be verified by: rst asserted one cycle after a store to 0x20 is accepted -> no ready pulse and a later load of 0x20 returns the prior value.
REQ-036 SHALL be verified by: with the macro defined, store to 0x0000_0402 and to 0x0001_0000 (ADDR_BITS=8) -> err=1 with ready, no write; without the macro, 0x0000_0400 aliases word 0.

Source files
------------

// File: rtl/kgp_dmem_responder.sv
// Wait-state data-memory responder: one request in flight, ready pulses WAIT_CYCLES+1 cycles after accept.
// Optional DMEM_BOUNDS_CHECK_EN: out-of-range or misaligned addresses complete with err=1 and no write.
module kgp_dmem_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_enable,
    input  logic        dmem_write_enable,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t               state, state_nxt;
    logic [3:0]           cnt, cnt_nxt;
    logic [ADDR_BITS-1:0] idx_q;
    logic [31:0]          wdata_q;
    logic                 we_q;
    logic                 fault_q;
    logic [ADDR_BITS-1:0] req_idx;
    logic                 req_fault;
    logic [ADDR_BITS-1:0] sel_idx;
    logic                 sel_we;
    logic                 sel_fault;
    logic                 enter_done;
    logic [31:0]          mem [0:(1<<ADDR_BITS)-1];

    assign req_idx = addr[ADDR_BITS+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign req_fault = (|addr[31:ADDR_BITS+2]) | (|addr[1:0]);
    assign err       = (state == DONE) & fault_q;
`else
    // Upper bits are dropped so addresses alias modulo the memory size.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:ADDR_BITS+2], addr[1:0], fault_q};
    assign req_fault        = 1'b0;
    assign err              = 1'b0;
`endif

    assign ready = (state == DONE);
    assign busy  = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (dmem_enable) begin
                    cnt_nxt   = 4'(WAIT_CYCLES);
                    state_nxt = (WAIT_CYCLES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With zero wait states the read happens on the accept edge itself, so the
    // live request fields are used until the latched copies are valid.
    assign sel_idx    = (state == IDLE) ? req_idx           : idx_q;
    assign sel_we     = (state == IDLE) ? dmem_write_enable : we_q;
    assign sel_fault  = (state == IDLE) ? req_fault         : fault_q;
    assign enter_done = (state_nxt == DONE) && (state != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata   <= 32'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && dmem_enable) begin
                idx_q   <= req_idx;
                wdata_q <= wdata;
                we_q    <= dmem_write_enable;
                fault_q <= req_fault;
            end
            if (enter_done && (sel_fault || !sel_we))
                rdata <= sel_fault ? 32'd0 : mem[sel_idx];
        end
    end

    // Memory has no reset; an access aborted by rst never reaches this write.
    always_ff @(posedge clk) begin
        if (!rst && state == DONE && we_q && !fault_q)
            mem[idx_q] <= wdata_q;
    end
endmodule

// File: tb/tb_kgp_dmem_responder.sv
// Directed bench: dut uses WAIT_CYCLES=2, dut0 uses WAIT_CYCLES=0 for the back-to-back case.
module tb_kgp_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        en, we;
    logic [31:0] addr, wdata, rdata;
    logic        ready, busy, err;
    logic        z_en, z_we;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic        z_ready, z_busy, z_err;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    kgp_dmem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .dmem_enable(en), .dmem_write_enable(we),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy), .err(err));

    kgp_dmem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .dmem_enable(z_en), .dmem_write_enable(z_we),
        .addr(z_addr), .wdata(z_wdata), .rdata(z_rdata), .ready(z_ready), .busy(z_busy), .err(z_err));

    // Drives one request on dut and waits (bounded) for its ready pulse.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic e);
        @(negedge clk);
        en = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        en = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0BAD_0BAD; we = ~w;
        lat = 1;
        while (!ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rdata;
        e  = err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        z_en = 1'b0; z_we = 1'b0; z_addr = 32'd0; z_wdata = 32'd0;
        repeat (2) @(negedge clk);
        total++;
        if ({ready, busy, err} !== 3'b000) begin
            bad++; $display("FAIL reset_flags: got %b want 000", {ready, busy, err});
        end
        total++;
        if (rdata !== 32'd0) begin
            bad++; $display("FAIL reset_rdata: got %h want 00000000", rdata);
        end
        total++;
        if ({z_ready, z_busy, z_err, z_rdata} !== 35'd0) begin
            bad++; $display("FAIL reset_dut0: got %b %h want 000 0", {z_ready, z_busy, z_err}, z_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_store_timing();
        logic [1:0] exp_rb [4] = '{2'b01, 2'b01, 2'b11, 2'b00};
        @(negedge clk);
        en = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            en = 1'b0; addr = 32'h14; wdata = 32'h0;
            total++;
            if ({ready, busy} !== exp_rb[k]) begin
                bad++; $display("FAIL store_timing_c%0d: got ready,busy=%b want %b", k + 1, {ready, busy}, exp_rb[k]);
            end
        end
        total++;
        if (rdata !== 32'd0) begin
            bad++; $display("FAIL store_rdata_unchanged: got %h want 00000000", rdata);
        end
    endtask

    task automatic test_load_hold();
        int lat; logic [31:0] rd; logic e;
        access(1'b0, 32'h10, 32'h0, lat, rd, e);
        total++;
        if (lat !== 3) begin
            bad++; $display("FAIL load_latency: got %0d want 3", lat);
        end
        total++;
        if (rd !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL load_data: got %h want deadbeef", rd);
        end
        repeat (5) @(negedge clk);
        total++;
        if (rdata !== 32'hDEAD_BEEF || busy !== 1'b0) begin
            bad++; $display("FAIL load_hold: got %h busy=%b want deadbeef busy=0", rdata, busy);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        z_en = 1'b1; z_we = 1'b1; z_addr = 32'h8; z_wdata = 32'hCAFE_0001;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            total++;
            if ({z_ready, z_busy} !== {2{k[0]}}) begin
                bad++; $display("FAIL b2b_c%0d: got ready,busy=%b want %b", k, {z_ready, z_busy}, {2{k[0]}});
            end
        end
        z_en = 1'b0;
        repeat (2) @(negedge clk);
        z_en = 1'b1; z_we = 1'b0; z_addr = 32'h8;
        @(negedge clk);
        z_en = 1'b0;
        total++;
        if (z_ready !== 1'b1 || z_rdata !== 32'hCAFE_0001) begin
            bad++; $display("FAIL b2b_load: got ready=%b %h want 1 cafe0001", z_ready, z_rdata);
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd; logic e; logic seen;
        access(1'b1, 32'h20, 32'h1111_1111, lat, rd, e);
        @(negedge clk);
        en = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h2222_2222;
        @(negedge clk);
        en = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({ready, busy} !== 2'b00 || rdata !== 32'd0) begin
            bad++; $display("FAIL abort_state: got ready,busy=%b rdata=%h want 00 0", {ready, busy}, rdata);
        end
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL abort_no_ready: got %b want 0", seen);
        end
        access(1'b0, 32'h20, 32'h0, lat, rd, e);
        total++;
        if (rd !== 32'h1111_1111) begin
            bad++; $display("FAIL abort_no_write: got %h want 11111111", rd);
        end
    endtask

    task automatic test_bounds();
        int lat; logic [31:0] rd; logic e;
        access(1'b1, 32'h0, 32'h1234_5678, lat, rd, e);
`ifdef DMEM_BOUNDS_CHECK_EN
        access(1'b1, 32'h0000_0402, 32'h5555_5555, lat, rd, e);
        total++;
        if (e !== 1'b1 || lat !== 3 || rd !== 32'd0) begin
            bad++; $display("FAIL fault_misaligned: got err=%b lat=%0d rd=%h want 1 3 0", e, lat, rd);
        end
        access(1'b1, 32'h0001_0000, 32'h6666_6666, lat, rd, e);
        total++;
        if (e !== 1'b1 || lat !== 3) begin
            bad++; $display("FAIL fault_range: got err=%b lat=%0d want 1 3", e, lat);
        end
        access(1'b0, 32'h0, 32'h0, lat, rd, e);
        total++;
        if (rd !== 32'h1234_5678 || e !== 1'b0) begin
            bad++; $display("FAIL fault_no_write: got %h err=%b want 12345678 0", rd, e);
        end
`else
        access(1'b1, 32'h0000_0400, 32'hA5A5_A5A5, lat, rd, e);
        access(1'b0, 32'h0, 32'h0, lat, rd, e);
        total++;
        if (rd !== 32'hA5A5_A5A5 || e !== 1'b0) begin
            bad++; $display("FAIL alias_word0: got %h err=%b want a5a5a5a5 0", rd, e);
        end
        access(1'b0, 32'h13, 32'h0, lat, rd, e);
        total++;
        if (rd !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL low_bits_ignored: got %h want deadbeef", rd);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_store_timing();
        test_load_hold();
        test_back_to_back();
        test_reset_abort();
        test_bounds();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
